// File: rtl/bus_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : bus_arbiter_pkg
// Purpose  : Shared cache-bus definitions: request packet layout, arbiter FSM
//            state encoding and index-width helper.
// Revision : 1.0 - initial release
// ============================================================================
package bus_arbiter_pkg;

    // Width of one memory data beat carried in a cache request packet
    localparam int DMA_DATA_WIDTH = 16;

    // Per-cache request packet
    typedef struct packed {
        logic                      we;
        logic [31:0]               addr;
        logic [DMA_DATA_WIDTH-1:0] wdata;
    } cache_bus_pkt_t;

    // Arbiter FSM: one transaction in flight at a time
    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_MEM_REQ  = 2'd1,
        ST_MEM_WAIT = 2'd2,
        ST_RESP     = 2'd3
    } arb_state_e;

    // Index width for n requesters; a single requester still needs one bit
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage : bus_arbiter_pkg
`default_nettype wire

// File: rtl/bus_arbiter_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : rr_arbiter
// Purpose  : Combinational round-robin winner selection. The search begins at
//            the priority pointer and wraps from the last requester to 0.
// Revision : 1.0 - initial release
// ============================================================================
module rr_arbiter
    import bus_arbiter_pkg::*;
#(
    parameter int num_reqs_p = 4,
    parameter int IDX_W      = idx_width(num_reqs_p)
) (
    input  logic [num_reqs_p-1:0] reqs_i,
    input  logic [IDX_W-1:0]      ptr_i,
    output logic [num_reqs_p-1:0] grant_o,
    output logic [IDX_W-1:0]      idx_o,
    output logic                  any_o
);

    logic [IDX_W:0]   w_sum;
    logic [IDX_W-1:0] w_cand;

    // Walk requesters starting at the pointer; first active one wins
    always_comb begin
        grant_o = '0;
        idx_o   = '0;
        any_o   = 1'b0;
        w_sum   = '0;
        w_cand  = '0;
        for (int i = 0; i < num_reqs_p; i++) begin
            w_sum = {1'b0, ptr_i} + (IDX_W+1)'(i);
            if (w_sum >= (IDX_W+1)'(num_reqs_p)) begin
                w_sum = w_sum - (IDX_W+1)'(num_reqs_p);
            end
            w_cand = w_sum[IDX_W-1:0];
            if (!any_o && reqs_i[w_cand]) begin
                any_o           = 1'b1;
                grant_o[w_cand] = 1'b1;
                idx_o           = w_cand;
            end
        end
    end

endmodule : rr_arbiter
`default_nettype wire

// File: rtl/bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : bus_arbiter
// Purpose  : Round-robin arbiter funnelling cache requests onto a single
//            memory port, one transaction at a time, with per-cache response.
// Revision : 1.0 - initial release
// ============================================================================
module bus_arbiter
    import bus_arbiter_pkg::*;
#(
    parameter int num_caches_p     = 4,
    parameter int dma_data_width_p = DMA_DATA_WIDTH
) (
    input  logic                                   clk_i,
    input  logic                                   reset_i,
    input  logic [num_caches_p-1:0]                cb_valid_i,
    input  cache_bus_pkt_t [num_caches_p-1:0]      cb_pkt_i,
    output logic [num_caches_p-1:0]                cb_yumi_o,
    output logic [num_caches_p-1:0]                cb_valid_o,
    output logic [dma_data_width_p-1:0]            cb_data_o,
    output logic                                   mem_valid_o,
    input  logic                                   mem_ready_i,
    output logic                                   mem_we_o,
    output logic [31:0]                            mem_addr_o,
    output logic [dma_data_width_p-1:0]            mem_wdata_o,
    input  logic                                   mem_valid_i,
    input  logic [dma_data_width_p-1:0]            mem_data_i
);

    localparam int C_IDX_W = idx_width(num_caches_p);

    arb_state_e                    r_state;
    arb_state_e                    w_next_state;
    logic [C_IDX_W-1:0]            r_ptr;
    logic [C_IDX_W-1:0]            r_grant_idx;
    cache_bus_pkt_t                r_pkt;
    logic [dma_data_width_p-1:0]   r_data;

    logic [num_caches_p-1:0]       w_rr_grant;
    logic [C_IDX_W-1:0]            w_rr_idx;
    logic                          w_rr_any;
    logic                          w_accept;

    rr_arbiter #(
        .num_reqs_p (num_caches_p),
        .IDX_W      (C_IDX_W)
    ) u_rr_arbiter (
        .reqs_i  (cb_valid_i),
        .ptr_i   (r_ptr),
        .grant_o (w_rr_grant),
        .idx_o   (w_rr_idx),
        .any_o   (w_rr_any)
    );

    // A request is only taken from IDLE and never while reset is held
    assign w_accept = (r_state == ST_IDLE) && w_rr_any && !reset_i;

    // State register
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE:     if (w_rr_any)    w_next_state = ST_MEM_REQ;
            ST_MEM_REQ:  if (mem_ready_i) w_next_state = ST_MEM_WAIT;
            ST_MEM_WAIT: if (mem_valid_i) w_next_state = ST_RESP;
            ST_RESP:                      w_next_state = ST_IDLE;
            default:                      w_next_state = ST_IDLE;
        endcase
    end

    // Latched request, returned data and round-robin pointer
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_ptr       <= '0;
            r_grant_idx <= '0;
            r_pkt       <= '0;
            r_data      <= '0;
        end else begin
            if (w_accept) begin
                r_pkt       <= cb_pkt_i[w_rr_idx];
                r_grant_idx <= w_rr_idx;
            end
            // Writes carry no data back, so the ack returns zero
            if ((r_state == ST_MEM_WAIT) && mem_valid_i) begin
                r_data <= r_pkt.we ? '0 : mem_data_i;
            end
            // Advance priority past the winner only once it has been served
            if (r_state == ST_RESP) begin
                if (r_grant_idx == C_IDX_W'(num_caches_p - 1)) begin
                    r_ptr <= '0;
                end else begin
                    r_ptr <= r_grant_idx + C_IDX_W'(1);
                end
            end
        end
    end

    // Outputs decoded from state; everything is silenced while reset is high
    always_comb begin
        cb_yumi_o   = '0;
        cb_valid_o  = '0;
        cb_data_o   = '0;
        mem_valid_o = 1'b0;
        if (w_accept) begin
            cb_yumi_o = w_rr_grant;
        end
        if (!reset_i && (r_state == ST_MEM_REQ)) begin
            mem_valid_o = 1'b1;
        end
        if (!reset_i && (r_state == ST_RESP)) begin
            cb_valid_o[r_grant_idx] = 1'b1;
            cb_data_o               = r_data;
        end
    end

    // Request fields come straight from the latched packet, stable until accepted
    assign mem_we_o    = r_pkt.we;
    assign mem_addr_o  = r_pkt.addr;
    assign mem_wdata_o = r_pkt.wdata;

endmodule : bus_arbiter
`default_nettype wire

// File: tb/tb_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_bus_arbiter
// Purpose  : Directed self-checking bench for bus_arbiter (4 caches, 16-bit).
// Revision : 1.0 - initial release
// ============================================================================
module tb_bus_arbiter;
    import bus_arbiter_pkg::*;

    localparam int N = 4;

    logic                  clk_i;
    logic                  reset_i;
    logic [N-1:0]          cb_valid_i;
    cache_bus_pkt_t [N-1:0] cb_pkt_i;
    logic [N-1:0]          cb_yumi_o;
    logic [N-1:0]          cb_valid_o;
    logic [15:0]           cb_data_o;
    logic                  mem_valid_o;
    logic                  mem_ready_i;
    logic                  mem_we_o;
    logic [31:0]           mem_addr_o;
    logic [15:0]           mem_wdata_o;
    logic                  mem_valid_i;
    logic [15:0]           mem_data_i;

    int checks   = 0;
    int failures = 0;

    bus_arbiter #(
        .num_caches_p     (N),
        .dma_data_width_p (16)
    ) dut (
        .clk_i       (clk_i),
        .reset_i     (reset_i),
        .cb_valid_i  (cb_valid_i),
        .cb_pkt_i    (cb_pkt_i),
        .cb_yumi_o   (cb_yumi_o),
        .cb_valid_o  (cb_valid_o),
        .cb_data_o   (cb_data_o),
        .mem_valid_o (mem_valid_o),
        .mem_ready_i (mem_ready_i),
        .mem_we_o    (mem_we_o),
        .mem_addr_o  (mem_addr_o),
        .mem_wdata_o (mem_wdata_o),
        .mem_valid_i (mem_valid_i),
        .mem_data_i  (mem_data_i)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs and checks live 1ns after the rising edge
    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic set_pkt(input int i, input logic we, input logic [31:0] addr,
                           input logic [15:0] wdata);
        cb_pkt_i[i].we    = we;
        cb_pkt_i[i].addr  = addr;
        cb_pkt_i[i].wdata = wdata;
    endtask

    task automatic do_reset();
        reset_i = 1'b1;
        tick();
        tick();
        reset_i = 1'b0;
    endtask

    // Full transaction from IDLE: grant, request held for ready_delay cycles,
    // one-cycle memory completion, response pulse, back to IDLE.
    task automatic run_txn(input string tag, input int idx, input logic we,
                           input logic [31:0] addr, input logic [15:0] wdata,
                           input int ready_delay, input logic [15:0] rdata);
        logic [N-1:0] oh;
        oh = '0;
        oh[idx] = 1'b1;
        chk({tag, ".yumi"}, 32'(cb_yumi_o), 32'(oh));
        chk({tag, ".memv_c0"}, 32'(mem_valid_o), 32'd0);
        tick();
        for (int d = 0; d <= ready_delay; d++) begin
            mem_ready_i = (d == ready_delay);
            #1;
            chk({tag, ".memv"}, 32'(mem_valid_o), 32'd1);
            chk({tag, ".we"}, 32'(mem_we_o), 32'(we));
            chk({tag, ".addr"}, mem_addr_o, addr);
            chk({tag, ".wdata"}, 32'(mem_wdata_o), 32'(wdata));
            chk({tag, ".yumi_busy"}, 32'(cb_yumi_o), 32'd0);
            tick();
        end
        mem_ready_i = 1'b0;
        chk({tag, ".memv_wait"}, 32'(mem_valid_o), 32'd0);
        chk({tag, ".cbv_wait"}, 32'(cb_valid_o), 32'd0);
        mem_valid_i = 1'b1;
        mem_data_i  = rdata;
        tick();
        mem_valid_i = 1'b0;
        mem_data_i  = 16'h0;
        chk({tag, ".cbv"}, 32'(cb_valid_o), 32'(oh));
        chk({tag, ".data"}, 32'(cb_data_o), we ? 32'd0 : 32'(rdata));
        chk({tag, ".yumi_resp"}, 32'(cb_yumi_o), 32'd0);
        tick();
        chk({tag, ".cbv_done"}, 32'(cb_valid_o), 32'd0);
    endtask

    initial begin
        reset_i     = 1'b1;
        cb_valid_i  = '1;
        cb_pkt_i    = '0;
        mem_ready_i = 1'b0;
        mem_valid_i = 1'b0;
        mem_data_i  = 16'h0;
        for (int i = 0; i < N; i++) set_pkt(i, 1'b0, 32'h100 + 32'(i), 16'h0);

        // Reset state, with requests pending that must not be accepted
        tick();
        tick();
        chk("rst.yumi", 32'(cb_yumi_o), 32'd0);
        chk("rst.cbv", 32'(cb_valid_o), 32'd0);
        chk("rst.memv", 32'(mem_valid_o), 32'd0);
        chk("rst.data", 32'(cb_data_o), 32'd0);
        cb_valid_i = '0;
        reset_i    = 1'b0;
        tick();
        chk("idle.yumi", 32'(cb_yumi_o), 32'd0);

        // Single read from cache 0 with minimum latency; valid drops after accept
        set_pkt(0, 1'b0, 32'h0010, 16'h0);
        cb_valid_i = 4'b0001;
        #1;
        chk("rd.yumi_c0", 32'(cb_yumi_o), 32'h1);
        tick();
        cb_valid_i  = 4'b0000;
        mem_ready_i = 1'b1;
        #1;
        chk("rd.memv_c1", 32'(mem_valid_o), 32'd1);
        chk("rd.addr_c1", mem_addr_o, 32'h0010);
        chk("rd.we_c1", 32'(mem_we_o), 32'd0);
        tick();
        mem_ready_i = 1'b0;
        mem_valid_i = 1'b1;
        mem_data_i  = 16'hBEEF;
        #1;
        chk("rd.memv_c2", 32'(mem_valid_o), 32'd0);
        chk("rd.cbv_c2", 32'(cb_valid_o), 32'd0);
        tick();
        mem_valid_i = 1'b0;
        mem_data_i  = 16'h0;
        chk("rd.cbv_c3", 32'(cb_valid_o), 32'h1);
        chk("rd.data_c3", 32'(cb_data_o), 32'hBEEF);
        tick();
        chk("rd.cbv_c4", 32'(cb_valid_o), 32'd0);
        chk("rd.data_c4", 32'(cb_data_o), 32'd0);

        // All caches requesting from a fresh pointer: 0,1,2,3,0
        do_reset();
        for (int i = 0; i < N; i++) set_pkt(i, 1'b0, 32'h200 + 32'(i), 16'h0);
        cb_valid_i = 4'b1111;
        #1;
        run_txn("rr0", 0, 1'b0, 32'h200, 16'h0, 0, 16'hA000);
        run_txn("rr1", 1, 1'b0, 32'h201, 16'h0, 0, 16'hA001);
        run_txn("rr2", 2, 1'b0, 32'h202, 16'h0, 1, 16'hA002);
        run_txn("rr3", 3, 1'b0, 32'h203, 16'h0, 0, 16'hA003);
        run_txn("rr4", 0, 1'b0, 32'h200, 16'h0, 0, 16'hA004);

        // Write from cache 2 with memory stalling 3 cycles; ack carries zero
        set_pkt(2, 1'b1, 32'h0040, 16'h1234);
        cb_valid_i = 4'b0100;
        #1;
        run_txn("wr", 2, 1'b1, 32'h0040, 16'h1234, 3, 16'h5555);

        // Pointer now at 3: requests on 1 and 3 serve 3 first, then 1
        set_pkt(1, 1'b0, 32'h0301, 16'h0);
        set_pkt(3, 1'b0, 32'h0303, 16'h0);
        cb_valid_i = 4'b1010;
        #1;
        run_txn("wrap3", 3, 1'b0, 32'h0303, 16'h0, 0, 16'hC003);
        run_txn("wrap1", 1, 1'b0, 32'h0301, 16'h0, 0, 16'hC001);

        // Reset while waiting on memory; stray completion afterwards is ignored
        cb_valid_i = 4'b0100;
        set_pkt(2, 1'b0, 32'h0402, 16'h0);
        #1;
        chk("abort.yumi", 32'(cb_yumi_o), 32'h4);
        tick();
        cb_valid_i  = 4'b0000;
        mem_ready_i = 1'b1;
        tick();
        mem_ready_i = 1'b0;
        reset_i     = 1'b1;
        tick();
        reset_i     = 1'b0;
        mem_valid_i = 1'b1;
        mem_data_i  = 16'hDEAD;
        #1;
        chk("abort.memv", 32'(mem_valid_o), 32'd0);
        tick();
        mem_valid_i = 1'b0;
        mem_data_i  = 16'h0;
        chk("abort.cbv1", 32'(cb_valid_o), 32'd0);
        chk("abort.data1", 32'(cb_data_o), 32'd0);
        tick();
        chk("abort.cbv2", 32'(cb_valid_o), 32'd0);
        cb_valid_i = 4'b0101;
        set_pkt(0, 1'b0, 32'h0500, 16'h0);
        set_pkt(2, 1'b0, 32'h0502, 16'h0);
        #1;
        run_txn("postrst", 0, 1'b0, 32'h0500, 16'h0, 0, 16'h7777);
        cb_valid_i = 4'b0000;

        // Spurious memory completion in IDLE
        mem_valid_i = 1'b1;
        mem_data_i  = 16'hFFFF;
        tick();
        mem_valid_i = 1'b0;
        mem_data_i  = 16'h0;
        chk("spur.cbv1", 32'(cb_valid_o), 32'd0);
        chk("spur.data1", 32'(cb_data_o), 32'd0);
        chk("spur.memv", 32'(mem_valid_o), 32'd0);
        tick();
        chk("spur.cbv2", 32'(cb_valid_o), 32'd0);
        chk("spur.data2", 32'(cb_data_o), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Absolute time bound so the run always terminates
    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule : tb_bus_arbiter
`default_nettype wire
